// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// A start/busy/done handshake brackets each WIDTH-cycle operation.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bit_s, carry_nxt, last_bit;

  always_comb begin
    bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    last_bit  = (cnt_q == CntW'(WIDTH - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Shift-based insert keeps WIDTH=1 legal (no empty part-select).
        part_d  = (part_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
        carry_d = carry_nxt;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB.
          sum_d   = part_d;
          cout_d  = carry_nxt;
          ovf_d   = carry_q ^ carry_nxt;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor. It computes a WIDTH-bit sum or difference one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. A start/busy/done handshake brackets each operation. It trades latency for area and is the sequential successor to the single-bit full-adder cell in the arithmetic library.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- cin  in  1  carry-in for add, borrow-in for subtract; sampled with start.
- busy  out  1  high while an operation is in RUN.
- done  out  1  one-cycle pulse when results become valid.
- sum  out  WIDTH  result register.
- cout  out  1  raw carry out of the MSB; in subtract mode 1 = no borrow.
- overflow  out  1  signed overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0; internal shift registers, carry and bit counter all 0.
- IDLE, start=1 at an edge:
  - load shift register A <= a;
  - load shift register B <= b XOR {WIDTH{sub}};
  - load carry <= cin XOR sub;
  - clear counter; go to RUN.
  - sub, a, b and cin are ignored when start=0.
- RUN, each edge:
  - partial sum bit = A[0] ^ B[0] ^ carry; shift it into a partial-result register at the MSB (right shift);
  - carry <= majority(A[0], B[0], carry);
  - shift A and B right by one; increment counter.
  - On the edge that processes bit WIDTH-1, also capture carry-into-MSB (carry before that bit) for overflow.
- Leaving RUN: after WIDTH bit edges, the final edge transfers the partial result to sum, and sets cout and overflow. That edge moves the state to DONE.
- DONE: done=1 for exactly one cycle; the next edge goes to IDLE unconditionally.
- start in RUN or DONE is ignored: no queueing, no restart.
- sum, cout and overflow change only on the RUN→DONE edge; they hold the previous result through a new RUN.
- Subtract semantics: a − b − cin, computed as a + ~b + ~cin (mod 2^WIDTH).
- Counter width is clog2(WIDTH)+1. WIDTH=1 must work: one RUN cycle.

## Timing
- Take the start-accept edge as edge k: busy=1 from edge k through edge k+WIDTH (exclusive).
- Bits are processed on edges k+1 … k+WIDTH.
- At edge k+WIDTH: state=DONE, done=1, busy=0, results valid.
- At edge k+WIDTH+1: state=IDLE, done=0.
- Earliest next start accept is edge k+WIDTH+2, so throughput is one operation per WIDTH+2 cycles.
- Latency from start edge to done high is WIDTH cycles.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately (asynchronously), all outputs take reset values, and no done pulse is produced.
- start held high continuously: a new operation is accepted on every IDLE visit.

## Test plan
- WIDTH=8, add, a=8'h3C, b=8'h55, cin=0 → sum=8'h91, cout=0, overflow=1; done exactly 8 cycles after the start edge; busy high for 8 cycles.
- WIDTH=8, add, a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, overflow=0. Repeat with cin=1 → sum=8'h01, cout=1.
- WIDTH=8, subtract: a=8'h10, b=8'h20, cin=0 → sum=8'hF0, cout=0, overflow=0. Then a=8'h80, b=8'h01 → sum=8'h7F, cout=1, overflow=1.
- WIDTH=8: pulse start again with different operands 3 cycles into RUN → ignored; first result is unchanged and done pulses once. sum holds its old value until the DONE edge.
- WIDTH=8: assert rst at the 5th RUN cycle → busy, done, sum, cout and overflow all 0 immediately. After release, a fresh 8'h01+8'h01 gives 8'h02.
- WIDTH=1: add, a=1, b=1, cin=0 → sum=0, cout=1, overflow=1, done 1 cycle after start. Also run a random regression against a reference model for WIDTH=1, 8 and 33.
